// File: rtl/sliding_flip_corrector_if.sv
// Word bus between the sliding detector and the flip corrector.
// The upstream side drives the sliced bits, per-position flags and delay tag;
// the corrector returns corrected words with their advanced delay tag.
interface sliding_flip_corrector_if #(
  parameter int width      = 16,
  parameter int flag_width = 3,
  parameter int tag_width  = 8
);
  logic                                 in_valid;
  logic [width-1:0]                     bits_in;
  logic [width-1:0][flag_width-1:0]     err_flags;
  logic [tag_width-1:0]                 bits_in_delay;
  logic                                 out_valid;
  logic [width-1:0]                     bits_out;
  logic [tag_width-1:0]                 bits_out_delay;

  modport master (
    output in_valid, bits_in, err_flags, bits_in_delay,
    input  out_valid, bits_out, bits_out_delay
  );

  modport slave (
    input  in_valid, bits_in, err_flags, bits_in_delay,
    output out_valid, bits_out, bits_out_delay
  );
endinterface

// File: rtl/sliding_flip_corrector.sv
// Sliding flip corrector: applies the flip pattern selected by each
// per-position error flag to the sliced bitstream, one word per valid cycle.
// Flips that run past the end of a word carry into the next word; overlapping
// flags are resolved greedily, earliest position first, by suppressing the
// depth-1 positions that follow a fired flag (also across word boundaries).
// Optional feature macro: FLIP_CORR_STATS_EN adds a saturating count of
// fired flags (flip_count_out) with a synchronous clear (stats_clear).
module sliding_flip_corrector #(
  parameter int width                = 16,
  parameter int num_of_flip_patterns = 4,
  parameter int flip_pattern_depth   = 3,
  parameter int flip_patterns [num_of_flip_patterns-1:0][flip_pattern_depth-1:0] =
    '{'{0, 1, 0}, '{0, 1, 1}, '{1, 1, 1}, '{1, 0, 1}},
  parameter int delay_width          = 4,
  parameter int width_width          = 4
) (
  input  logic                      clk,
  input  logic                      rstb,
`ifdef FLIP_CORR_STATS_EN
  input  logic                      stats_clear,
  output logic [15:0]               flip_count_out,
`endif
  sliding_flip_corrector_if.slave   bus
);

  localparam int flag_w  = $clog2(num_of_flip_patterns + 1);
  localparam int tag_w   = delay_width + width_width;
  // A depth-1 pattern never carries; keep a 1-bit (always zero) carry then.
  localparam int carry_w = (flip_pattern_depth > 1) ? flip_pattern_depth - 1 : 1;
  localparam int skip_w  = (flip_pattern_depth > 1) ? $clog2(flip_pattern_depth) : 1;

  logic [carry_w-1:0]       carry;
  logic [skip_w-1:0]        skip_cnt;

  // Flip mask extended past the word end; the top carry_w bits feed the next word.
  logic [width+carry_w-1:0] ext_mask;
  logic [skip_w-1:0]        suppress;
  logic [width-1:0]         corrected;
`ifdef FLIP_CORR_STATS_EN
  logic [15:0]              fire_cnt;
  logic [16:0]              cnt_sum;
`endif

  // Greedy scan of the flags, earliest first, building this word's flip mask.
  always_comb begin
    ext_mask = '0;
    suppress = skip_cnt;
`ifdef FLIP_CORR_STATS_EN
    fire_cnt = '0;
`endif
    for (int i = 0; i < width; i++) begin
      if (suppress != '0) begin
        suppress = suppress - skip_w'(1);
      end else begin
        // Flag values above the pattern count match no k and act as "no flip".
        for (int k = 0; k < num_of_flip_patterns; k++) begin
          if (bus.err_flags[i] == flag_w'(k + 1)) begin
            for (int j = 0; j < flip_pattern_depth; j++) begin
              if (flip_patterns[k][j] != 0) begin
                ext_mask[i+j] = ~ext_mask[i+j];
              end
            end
            suppress = skip_w'(flip_pattern_depth - 1);
`ifdef FLIP_CORR_STATS_EN
            fire_cnt = fire_cnt + 16'd1;
`endif
          end
        end
      end
    end
    corrected = bus.bits_in ^ ext_mask[width-1:0] ^ {{(width-carry_w){1'b0}}, carry};
  end

  // Output word register plus the carry/suppress state that crosses words;
  // gaps leave carry and skip_cnt untouched for the next valid word.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      bus.out_valid      <= 1'b0;
      bus.bits_out       <= '0;
      bus.bits_out_delay <= '0;
      carry              <= '0;
      skip_cnt           <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.bits_out       <= corrected;
        bus.bits_out_delay <= bus.bits_in_delay + tag_w'(1 << width_width);
        carry              <= ext_mask[width +: carry_w];
        skip_cnt           <= suppress;
      end
    end
  end

`ifdef FLIP_CORR_STATS_EN
  assign cnt_sum = {1'b0, flip_count_out} + {1'b0, fire_cnt};

  // Saturating fired-flag counter; a clear wins over a same-cycle add.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      flip_count_out <= '0;
    end else if (stats_clear) begin
      flip_count_out <= '0;
    end else if (bus.in_valid) begin
      flip_count_out <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_sliding_flip_corrector.sv
// Testbench for sliding_flip_corrector: directed words with hand-computed
// literals, checked every cycle against a bit-stream level reference model.
module tb_sliding_flip_corrector;

  logic clk;
  logic rstb;
`ifdef FLIP_CORR_STATS_EN
  logic        stats_clear;
  logic [15:0] flip_count_out;
`endif

  sliding_flip_corrector_if #(.width(16), .flag_width(3), .tag_width(8)) bus ();

  sliding_flip_corrector dut (
    .clk            (clk),
    .rstb           (rstb),
`ifdef FLIP_CORR_STATS_EN
    .stats_clear    (stats_clear),
    .flip_count_out (flip_count_out),
`endif
    .bus            (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Pattern k as an offset mask: bit j set means bit i+j flips.
  logic [2:0] pat_mask [4] = '{3'b101, 3'b111, 3'b011, 3'b010};

  // Reference model: the stream as absolute bit positions.
  bit          m_tog [int];
  int          m_base  = 0;
  int          m_block = 0;
  logic [15:0] m_last_bits  = '0;
  logic [7:0]  m_last_delay = '0;
  int          m_cnt = 0;

  // Staged expectation (for the output after the next edge) and current one.
  logic        stg_valid = 0, cur_valid = 0;
  logic [15:0] stg_bits = '0, cur_bits = '0;
  logic [7:0]  stg_delay = '0, cur_delay = '0;
  int          stg_cnt = 0, cur_cnt = 0;
  logic        stg_lit_en = 0, cur_lit_en = 0;
  logic [15:0] stg_lit = '0, cur_lit = '0;
  string       stg_name = "", cur_name = "";

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cur_valid  = stg_valid;
    cur_bits   = stg_bits;
    cur_delay  = stg_delay;
    cur_cnt    = stg_cnt;
    cur_lit_en = stg_lit_en;
    cur_lit    = stg_lit;
    cur_name   = stg_name;
  end

  // Single compare process: outputs versus model every cycle, plus literals.
  always @(negedge clk) begin
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, cur_valid});
    chk("bits_out", {16'd0, bus.bits_out}, {16'd0, cur_bits});
    chk("bits_out_delay", {24'd0, bus.bits_out_delay}, {24'd0, cur_delay});
`ifdef FLIP_CORR_STATS_EN
    chk("flip_count_out", {16'd0, flip_count_out}, cur_cnt);
`endif
    if (cur_lit_en) begin
      chk({cur_name, "_dut"}, {16'd0, bus.bits_out}, {16'd0, cur_lit});
      chk({cur_name, "_model"}, {16'd0, cur_bits}, {16'd0, cur_lit});
    end
  end

  task automatic model_word(input logic [15:0] b, input logic [15:0][2:0] f,
                            output logic [15:0] e, output int fires);
    int a;
    logic [2:0] fl;
    e = b;
    fires = 0;
    for (int i = 0; i < 16; i++) begin
      a  = m_base + i;
      fl = f[i];
      if (a >= m_block && fl >= 3'd1 && fl <= 3'd4) begin
        for (int j = 0; j < 3; j++) begin
          if (pat_mask[fl-3'd1][j]) begin
            if (m_tog.exists(a + j)) m_tog[a+j] = ~m_tog[a+j];
            else m_tog[a+j] = 1'b1;
          end
        end
        m_block = a + 3;
        fires++;
      end
      if (m_tog.exists(a)) begin
        e[i] = e[i] ^ m_tog[a];
        m_tog.delete(a);
      end
    end
    m_base += 16;
  endtask

  task automatic send(input logic [15:0] b, input logic [15:0][2:0] f, input logic [7:0] d,
                      input logic lit_en, input logic [15:0] lit, input string name);
    logic [15:0] e;
    int fires;
    @(posedge clk);
    #1;
    rstb = 1'b1;
`ifdef FLIP_CORR_STATS_EN
    stats_clear = 1'b0;
`endif
    bus.in_valid      = 1'b1;
    bus.bits_in       = b;
    bus.err_flags     = f;
    bus.bits_in_delay = d;
    model_word(b, f, e, fires);
    m_last_bits  = e;
    m_last_delay = d + 8'h10;
    m_cnt = (m_cnt + fires > 65535) ? 65535 : m_cnt + fires;
    stg_valid  = 1'b1;
    stg_bits   = m_last_bits;
    stg_delay  = m_last_delay;
    stg_cnt    = m_cnt;
    stg_lit_en = lit_en;
    stg_lit    = lit;
    stg_name   = name;
  endtask

  task automatic idle(input int n, input logic clr, input logic lit_en, input string name);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      rstb = 1'b1;
      bus.in_valid  = 1'b0;
      bus.bits_in   = $urandom;
      bus.err_flags = '0;
`ifdef FLIP_CORR_STATS_EN
      stats_clear = clr;
      if (clr) m_cnt = 0;
`endif
      stg_valid  = 1'b0;
      stg_bits   = m_last_bits;
      stg_delay  = m_last_delay;
      stg_cnt    = m_cnt;
      stg_lit_en = lit_en;
      stg_lit    = m_last_bits;
      stg_name   = name;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstb = 1'b0;
    bus.in_valid = 1'b0;
    m_tog.delete();
    m_block = m_base;
    m_last_bits  = '0;
    m_last_delay = '0;
    m_cnt = 0;
    stg_valid = 0; stg_bits = '0; stg_delay = '0; stg_cnt = 0; stg_lit_en = 0;
    cur_valid = 0; cur_bits = '0; cur_delay = '0; cur_cnt = 0; cur_lit_en = 0;
  endtask

  function automatic logic [15:0][2:0] fl2(input int p0, input int v0, input int p1, input int v1);
    logic [15:0][2:0] f;
    f = '0;
    if (p0 >= 0) f[p0] = 3'(v0);
    if (p1 >= 0) f[p1] = 3'(v1);
    return f;
  endfunction

  initial begin
    rstb = 1'b0;
    bus.in_valid      = 1'b0;
    bus.bits_in       = '0;
    bus.err_flags     = '0;
    bus.bits_in_delay = '0;
`ifdef FLIP_CORR_STATS_EN
    stats_clear = 1'b0;
`endif
    // Held in reset for a few cycles: outputs must read as the reset values.
    repeat (3) @(posedge clk);

    send(16'hA5A5, fl2(-1, 0, -1, 0), 8'h03, 1, 16'hA5A5, "passthru");
    idle(1, 0, 1, "hold_after_gap");
    send(16'h0000, fl2(0, 1, -1, 0), 8'h20, 1, 16'h0005, "pat0_pos0");
    send(16'h0000, fl2(15, 4, -1, 0), 8'h21, 1, 16'h0000, "pat3_pos15");
    send(16'h0000, fl2(-1, 0, -1, 0), 8'h22, 1, 16'h0001, "carry_next");
    send(16'h0000, fl2(3, 2, 4, 1), 8'h23, 1, 16'h0038, "overlap_greedy");
    send(16'h0000, fl2(15, 2, -1, 0), 8'h24, 1, 16'h8000, "pat1_pos15");
    idle(3, 0, 0, "");
    send(16'h0000, fl2(0, 1, -1, 0), 8'h25, 1, 16'h0003, "carry_over_gap");
    send(16'h0000, fl2(14, 2, -1, 0), 8'h26, 1, 16'hC000, "pat1_pos14");
    send(16'h0000, fl2(0, 1, 1, 3), 8'h27, 1, 16'h0007, "skip_one_then_fire");
    send(16'hFFFF, fl2(5, 7, 9, 5), 8'hF8, 1, 16'hFFFF, "out_of_range_flag");

    // Reset between a word carrying overflow and the next words.
    send(16'h0000, fl2(15, 2, -1, 0), 8'h30, 1, 16'h8000, "pre_reset_word");
    do_reset();
    send(16'h1234, fl2(-1, 0, -1, 0), 8'h31, 1, 16'h1234, "after_reset_clean");
    send(16'h0000, fl2(0, 1, -1, 0), 8'h32, 1, 16'h0005, "after_reset_unsuppressed");

    idle(1, 1, 0, "");
    // Back-to-back words with sparse flags, some out of range.
    for (int w = 0; w < 24; w++) begin
      logic [15:0][2:0] f;
      f = '0;
      for (int i = 0; i < 16; i++)
        if ($urandom_range(0, 4) == 0) f[i] = 3'($urandom_range(1, 7));
      send(16'($urandom), f, 8'($urandom), 0, 16'h0000, "");
      if (w % 7 == 6) idle(1, 0, 0, "");
    end
    idle(3, 0, 0, "");

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
